// File: rtl/mb_cam_ctl_if.sv
// -----------------------------------------------------------------------------
// mb_cam_ctl_if
//   Bundles every non-clock signal of the miss-buffer CAM control stage.
//   That covers the allocate, deallocate, lookup and read request/response
//   channels toward the miss-buffer pipeline, and the write, lookup and read
//   ports toward the 16 x 40 CAM macro.
//
//   modport slave  : the control stage (mb_cam_ctl)
//   modport master : the environment around it (pipeline + CAM macro)
//
//   Ports (slave view):
//     alloc_vld/alloc_addr       in  : allocate request
//     alloc_rdy/alloc_idx        out : free entry available / entry granted
//     dealloc_vld/dealloc_idx    in  : release request
//     dealloc_err                out : release of an invalid entry (pulse)
//     lkup_vld/lkup_key          in  : lookup request, key = addr[AW-1:8]
//     lkup_done/hit/hit_idx/multi out: qualified lookup result (pulse)
//     rd_vld/rd_idx              in  : read request
//     rd_data_vld/rd_data/rd_err out : read result (pulse)
//     vld_vec/count              out : entry valid bits / population
//     cam_*                      out : CAM write, lookup and read ports
//     cam_match/cam_dout         in  : raw CAM match vector / read data
// -----------------------------------------------------------------------------
interface mb_cam_ctl_if #(
  parameter int ENTRIES = 16,
  parameter int AW      = 40
);
  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);

  logic               alloc_vld;
  logic [AW-1:0]      alloc_addr;
  logic               alloc_rdy;
  logic [IW-1:0]      alloc_idx;

  logic               dealloc_vld;
  logic [IW-1:0]      dealloc_idx;
  logic               dealloc_err;

  logic               lkup_vld;
  logic [AW-9:0]      lkup_key;
  logic               lkup_done;
  logic               lkup_hit;
  logic [IW-1:0]      lkup_hit_idx;
  logic               lkup_multi;

  logic               rd_vld;
  logic [IW-1:0]      rd_idx;
  logic               rd_data_vld;
  logic [AW-1:0]      rd_data;
  logic               rd_err;

  logic [ENTRIES-1:0] vld_vec;
  logic [CW-1:0]      count;

  logic               cam_write_en;
  logic [ENTRIES-1:0] cam_adr_w;
  logic [AW-1:0]      cam_din;
  logic               cam_lookup_en;
  logic [AW-9:0]      cam_key;
  logic               cam_read_en;
  logic [ENTRIES-1:0] cam_adr_r;
  logic [ENTRIES-1:0] cam_match;
  logic [AW-1:0]      cam_dout;

  modport slave (
    input  alloc_vld, alloc_addr, dealloc_vld, dealloc_idx,
           lkup_vld, lkup_key, rd_vld, rd_idx, cam_match, cam_dout,
    output alloc_rdy, alloc_idx, dealloc_err,
           lkup_done, lkup_hit, lkup_hit_idx, lkup_multi,
           rd_data_vld, rd_data, rd_err, vld_vec, count,
           cam_write_en, cam_adr_w, cam_din, cam_lookup_en, cam_key,
           cam_read_en, cam_adr_r
  );

  modport master (
    output alloc_vld, alloc_addr, dealloc_vld, dealloc_idx,
           lkup_vld, lkup_key, rd_vld, rd_idx, cam_match, cam_dout,
    input  alloc_rdy, alloc_idx, dealloc_err,
           lkup_done, lkup_hit, lkup_hit_idx, lkup_multi,
           rd_data_vld, rd_data, rd_err, vld_vec, count,
           cam_write_en, cam_adr_w, cam_din, cam_lookup_en, cam_key,
           cam_read_en, cam_adr_r
  );
endinterface

// File: rtl/mb_cam_ctl.sv
// -----------------------------------------------------------------------------
// mb_cam_ctl
//   Control stage around the miss-buffer CAM. It owns the per-entry valid bits
//   and grants the lowest free entry on allocate. It drives the CAM write,
//   lookup and read ports combinationally from accepted requests. Two edges
//   later it returns the lookup and read results: the raw match vector is
//   qualified with the valid bits sampled when the lookup was issued.
//
//   Ports:
//     rclk  : clock
//     rst_l : asynchronous active-low reset
//     bus   : mb_cam_ctl_if.slave, all request/response and CAM signals
// -----------------------------------------------------------------------------
module mb_cam_ctl #(
  parameter int ENTRIES = 16,
  parameter int AW      = 40
) (
  input  logic         rclk,
  input  logic         rst_l,
  mb_cam_ctl_if.slave  bus
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);

  typedef logic [ENTRIES-1:0] vec_t;

  // architectural state
  vec_t          vld_vec_q;
  logic [CW-1:0] count_q;
  logic          dealloc_err_q;

  // lookup pipeline: stage 1 holds the qualifying mask, stage 2 the result
  logic          lk_s1_vld_q;
  vec_t          qual_q;
  logic          lkup_done_q;
  logic          lkup_hit_q;
  logic [IW-1:0] lkup_hit_idx_q;
  logic          lkup_multi_q;

  // read pipeline
  logic          rd_s1_vld_q;
  logic          rd_s1_err_q;
  logic          rd_data_vld_q;
  logic [AW-1:0] rd_data_q;
  logic          rd_err_q;

  // combinational request decode
  logic          alloc_rdy;
  logic          alloc_acc;
  logic [IW-1:0] free_idx;
  vec_t          alloc_oh;
  vec_t          dealloc_oh;
  logic          dealloc_ok;
  logic          rd_block;
  logic          rd_go;
  vec_t          q;
  logic [IW-1:0] q_low_idx;

  // Lowest free entry: scan downward so the last (lowest) hit wins.
  // NOTE: every always_comb output gets a default before the loop, otherwise
  // the paths that never assign it would infer a latch.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!vld_vec_q[i]) free_idx = IW'(i);
    end
  end

  // count tracks popcount(vld_vec), so "not full" is a cheap compare
  assign alloc_rdy  = (count_q != CW'(ENTRIES));
  assign alloc_acc  = bus.alloc_vld & alloc_rdy;
  assign alloc_oh   = alloc_acc ? (vec_t'(1) << free_idx) : '0;
  assign dealloc_oh = bus.dealloc_vld ? (vec_t'(1) << bus.dealloc_idx) : '0;
  assign dealloc_ok = bus.dealloc_vld & vld_vec_q[bus.dealloc_idx];

  // A read of the entry being written this cycle would race the CAM write;
  // suppress it at the CAM and report it as an error two edges later.
  assign rd_block = bus.rd_vld & alloc_acc & (bus.rd_idx == free_idx);
  assign rd_go    = bus.rd_vld & ~rd_block;

  // stage-2 qualification of the raw CAM match vector
  assign q = bus.cam_match & qual_q;

  always_comb begin
    q_low_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (q[i]) q_low_idx = IW'(i);
    end
  end

  // CAM port drive, combinational from the accepted requests
  assign bus.cam_write_en  = alloc_acc;
  assign bus.cam_adr_w     = alloc_oh;
  assign bus.cam_din       = bus.alloc_addr;
  assign bus.cam_lookup_en = bus.lkup_vld;
  assign bus.cam_key       = bus.lkup_key;
  assign bus.cam_read_en   = rd_go;
  assign bus.cam_adr_r     = rd_go ? (vec_t'(1) << bus.rd_idx) : '0;

  assign bus.alloc_rdy = alloc_rdy;
  assign bus.alloc_idx = free_idx;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, which the pre-edge qualification relies on.
  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      vld_vec_q      <= '0;
      count_q        <= '0;
      dealloc_err_q  <= 1'b0;
      lk_s1_vld_q    <= 1'b0;
      qual_q         <= '0;
      lkup_done_q    <= 1'b0;
      lkup_hit_q     <= 1'b0;
      lkup_hit_idx_q <= '0;
      lkup_multi_q   <= 1'b0;
      rd_s1_vld_q    <= 1'b0;
      rd_s1_err_q    <= 1'b0;
      rd_data_vld_q  <= 1'b0;
      rd_data_q      <= '0;
      rd_err_q       <= 1'b0;
    end else begin
      // An invalid dealloc leaves state alone; a valid one never targets the
      // entry being granted, so set and clear cannot collide.
      vld_vec_q     <= (vld_vec_q | alloc_oh) & ~(dealloc_ok ? dealloc_oh : '0);
      count_q       <= count_q + CW'(alloc_acc) - CW'(dealloc_ok);
      dealloc_err_q <= bus.dealloc_vld & ~dealloc_ok;

      // The entry written this cycle is excluded: the CAM returns garbage on
      // it. An entry being freed this cycle is no longer a legal hit either.
      lk_s1_vld_q <= bus.lkup_vld;
      qual_q      <= bus.lkup_vld ? (vld_vec_q & ~dealloc_oh & ~alloc_oh) : '0;

      lkup_done_q    <= lk_s1_vld_q;
      lkup_hit_q     <= |q;
      lkup_hit_idx_q <= q_low_idx;
      // clearing the lowest set bit leaves something only if two or more hit
      lkup_multi_q   <= |(q & (q - vec_t'(1)));

      rd_s1_vld_q   <= bus.rd_vld;
      rd_s1_err_q   <= rd_block;
      rd_data_vld_q <= rd_s1_vld_q;
      rd_err_q      <= rd_s1_vld_q & rd_s1_err_q;
      rd_data_q     <= (rd_s1_vld_q && !rd_s1_err_q) ? bus.cam_dout : '0;
    end
  end

  assign bus.vld_vec      = vld_vec_q;
  assign bus.count        = count_q;
  assign bus.dealloc_err  = dealloc_err_q;
  assign bus.lkup_done    = lkup_done_q;
  assign bus.lkup_hit     = lkup_hit_q;
  assign bus.lkup_hit_idx = lkup_hit_idx_q;
  assign bus.lkup_multi   = lkup_multi_q;
  assign bus.rd_data_vld  = rd_data_vld_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_err       = rd_err_q;

endmodule
